maze_player_ctrl: RTL and testbench

- Sits between the maze pixel ROM and the OLED driver.
- Owns the player sprite position and moves it one pixel per movement tick, driven by the direction buttons.
- Before each move it checks for wall collisions through a dedicated probe port on a second maze ROM instance.
- Overlays the player square onto the maze pixel stream and produces the final oled_data. It also latches a goal flag when the player touches goal-coloured pixels.

---
 rtl/maze_pkg.sv | 22 ++
 rtl/maze_xy_to_index.sv | 19 +
 rtl/maze_player_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_maze_player_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared screen geometry, colours and FSM encoding for the maze player
//
// Purpose: constants shared by the player controller, its index helper and the bench.
//   SCREEN_W/SCREEN_H : OLED geometry in pixels
//   IDX_W             : width of a linear pixel index (0..6143)
//   WALL_COL/GOAL_COL : maze colours that block movement / mark the goal
//   ST_*              : player FSM state encoding
package maze_pkg;

  localparam int          SCREEN_W = 96;
  localparam int          SCREEN_H = 64;
  localparam int          IDX_W    = 13;

  localparam logic [15:0] WALL_COL = 16'hFFFF;
  localparam logic [15:0] GOAL_COL = 16'h001F;

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_PROBE  = 2'd1;
  localparam logic [1:0]  ST_DRAIN  = 2'd2;
  localparam logic [1:0]  ST_COMMIT = 2'd3;

endpackage

// File: rtl/maze_xy_to_index.sv
// rtl/maze_xy_to_index.sv - combinational (x, y) to linear pixel index, y*96 + x
//
// Purpose: converts a screen coordinate to a ROM index without a multiplier.
// Ports:
//   x_i     in  7   column 0..95
//   y_i     in  6   row 0..63
//   index_o out 13  y*96 + x
module maze_xy_to_index
  import maze_pkg::*;
(
  input  logic [6:0]       x_i,
  input  logic [5:0]       y_i,
  output logic [IDX_W-1:0] index_o
);

  // 96 = 64 + 32, so y*96 is two shifted copies of y.
  assign index_o = {1'b0, y_i, 6'b0} + {2'b0, y_i, 5'b0} + {6'b0, x_i};

endmodule

// File: rtl/maze_player_ctrl.sv
// rtl/maze_player_ctrl.sv - player sprite position, wall-checked movement and display overlay
//
// Purpose: moves a SIZE x SIZE player square one pixel per accepted movement tick,
// probing the maze ROM for walls before each move, overlays the square onto the maze
// pixel stream and latches a sticky goal flag.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   move_tick                  single-cycle movement strobe
//   btn_u/btn_d/btn_l/btn_r    level direction buttons
//   pixel_index, maze_pixel    display index in, maze colour one cycle later
//   probe_index, probe_data    collision probe to second ROM, data one cycle later
//   oled_data                  final colour, two cycles after pixel_index
//   player_x, player_y         committed top-left position
//   busy                       a move is being evaluated
//   goal_reached               sticky, freezes all movement
module maze_player_ctrl
  import maze_pkg::*;
#(
  parameter int          SIZE       = 3,
  parameter int          START_X    = 86,
  parameter int          START_Y    = 3,
  parameter logic [15:0] PLAYER_COL = 16'h07E0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             move_tick,
  input  logic             btn_u,
  input  logic             btn_d,
  input  logic             btn_l,
  input  logic             btn_r,
  input  logic [IDX_W-1:0] pixel_index,
  input  logic [15:0]      maze_pixel,
  output logic [IDX_W-1:0] probe_index,
  input  logic [15:0]      probe_data,
  output logic [15:0]      oled_data,
  output logic [6:0]       player_x,
  output logic [5:0]       player_y,
  output logic             busy,
  output logic             goal_reached
);

  localparam int OW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [1:0]       state_q, state_d;
  logic [6:0]       px_q, px_d, cx_q, cx_d;
  logic [5:0]       py_q, py_d, cy_q, cy_d;
  logic [OW-1:0]    ox_q, ox_d, oy_q, oy_d;
  logic             hit_goal_q, hit_goal_d;
  logic             goal_q, goal_d;
  logic [IDX_W-1:0] probe_q, probe_d;
  logic [IDX_W-1:0] idx_d1_q;
  logic [15:0]      oled_q, oled_d;

  // Candidate position; a left/up step from 0 wraps to all-ones and fails the bound test.
  logic [7:0]       cand_x;
  logic [6:0]       cand_y;
  logic             in_bounds, one_btn, first_issue, last_issue;
  logic [6:0]       probe_x;
  logic [5:0]       probe_y;
  logic [IDX_W-1:0] probe_idx;

  assign cand_x    = {1'b0, px_q} + (btn_r ? 8'd1 : (btn_l ? 8'hFF : 8'd0));
  assign cand_y    = {1'b0, py_q} + (btn_d ? 7'd1 : (btn_u ? 7'h7F : 7'd0));
  assign in_bounds = ({1'b0, cand_x} + 9'(SIZE) <= 9'(SCREEN_W)) &&
                     ({1'b0, cand_y} + 8'(SIZE) <= 8'(SCREEN_H));
  assign one_btn   = $onehot({btn_u, btn_d, btn_l, btn_r});

  assign first_issue = (ox_q == '0) && (oy_q == '0);
  assign last_issue  = (ox_q == OW'(SIZE - 1)) && (oy_q == OW'(SIZE - 1));
  assign probe_x     = cx_q + 7'(ox_q);
  assign probe_y     = cy_q + 6'(oy_q);

  maze_xy_to_index u_probe_idx (
    .x_i    (probe_x),
    .y_i    (probe_y),
    .index_o(probe_idx)
  );

  // The probe address is driven live in PROBE so its data returns while the FSM
  // still has a cycle to react; elsewhere the last issued index is held.
  assign probe_index = (state_q == ST_PROBE) ? probe_idx : probe_q;

  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    hit_goal_d = hit_goal_q;
    goal_d     = goal_q;
    probe_d    = probe_q;
    case (state_q)
      ST_IDLE: begin
        if (move_tick && one_btn && !goal_q && in_bounds) begin
          cx_d       = cand_x[6:0];
          cy_d       = cand_y[5:0];
          ox_d       = '0;
          oy_d       = '0;
          hit_goal_d = 1'b0;
          state_d    = ST_PROBE;
        end
      end
      ST_PROBE: begin
        probe_d = probe_idx;
        // probe_data belongs to the index issued on the previous cycle.
        if (!first_issue && probe_data == WALL_COL) begin
          state_d = ST_IDLE;
        end else begin
          if (!first_issue && probe_data == GOAL_COL) hit_goal_d = 1'b1;
          if (last_issue) begin
            state_d = ST_DRAIN;
          end else if (ox_q == OW'(SIZE - 1)) begin
            ox_d = '0;
            oy_d = oy_q + OW'(1);
          end else begin
            ox_d = ox_q + OW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (probe_data == WALL_COL) begin
          state_d = ST_IDLE;
        end else begin
          if (probe_data == GOAL_COL) hit_goal_d = 1'b1;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        px_d    = cx_q;
        py_d    = cy_q;
        goal_d  = goal_q | hit_goal_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Overlay: one row-start index per sprite row; the square never wraps because
  // committed positions always keep it fully on screen.
  logic [IDX_W-1:0] row_base [SIZE];
  logic [SIZE-1:0]  in_row;

  for (genvar r = 0; r < SIZE; r++) begin : g_row
    maze_xy_to_index u_row_idx (
      .x_i    (px_q),
      .y_i    (py_q + 6'(r)),
      .index_o(row_base[r])
    );
    assign in_row[r] = (idx_d1_q >= row_base[r]) && (idx_d1_q < row_base[r] + IDX_W'(SIZE));
  end

  assign oled_d = (|in_row) ? PLAYER_COL : maze_pixel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      px_q       <= 7'(START_X);
      py_q       <= 6'(START_Y);
      cx_q       <= '0;
      cy_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      hit_goal_q <= 1'b0;
      goal_q     <= 1'b0;
      probe_q    <= '0;
      idx_d1_q   <= '0;
      oled_q     <= '0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      hit_goal_q <= hit_goal_d;
      goal_q     <= goal_d;
      probe_q    <= probe_d;
      idx_d1_q   <= pixel_index;
      oled_q     <= oled_d;
    end
  end

  assign oled_data    = oled_q;
  assign player_x     = px_q;
  assign player_y     = py_q;
  assign busy         = (state_q != ST_IDLE);
  assign goal_reached = goal_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// tb/tb_maze_player_ctrl.sv - scoreboard bench for maze_player_ctrl
module tb_maze_player_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        move_tick = 1'b0;
  logic        btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic [12:0] pixel_index = '0;
  logic [15:0] maze_pixel = '0;
  logic [12:0] probe_index;
  logic [15:0] probe_data = '0;
  logic [15:0] oled_data;
  logic [6:0]  player_x;
  logic [5:0]  player_y;
  logic        busy, goal_reached;

  logic        snap = 1'b0;
  logic        pix_tag = 1'b0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    string name;
    int    x, y, goal, bmin, bmax, chk_oled, oled;
  } item_t;

  item_t       exp_q[$];
  int          pix_q[$];
  logic [15:0] maze [6144];

  always #5 clk = ~clk;

  // Synchronous ROM models: data is valid the cycle after the index.
  always @(posedge clk) begin
    maze_pixel <= maze[pixel_index];
    probe_data <= maze[probe_index];
  end

  maze_player_ctrl dut (
    .clk(clk), .rst_n(rst_n), .move_tick(move_tick),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .pixel_index(pixel_index), .maze_pixel(maze_pixel),
    .probe_index(probe_index), .probe_data(probe_data),
    .oled_data(oled_data), .player_x(player_x), .player_y(player_y),
    .busy(busy), .goal_reached(goal_reached)
  );

  function automatic int idx(int x, int y);
    return y * 96 + x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_maze(logic [15:0] v);
    for (int i = 0; i < 6144; i++) maze[i] = v;
  endtask

  task automatic expect_state(string n, int x, int y, int g, int bmin, int bmax,
                              int co = 0, int ov = 0);
    item_t it;
    it.name = n; it.x = x; it.y = y; it.goal = g;
    it.bmin = bmin; it.bmax = bmax; it.chk_oled = co; it.oled = ov;
    exp_q.push_back(it);
  endtask

  task automatic snap_pulse();
    step(); snap = 1'b1;
    step(); snap = 1'b0;
  endtask

  task automatic move(string n, logic u, logic d, logic l, logic r,
                      int ex, int ey, int eg, int bmin, int bmax, bit rejected);
    expect_state(n, ex, ey, eg, bmin, bmax);
    step();
    {btn_u, btn_d, btn_l, btn_r} = {u, d, l, r};
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
    {btn_u, btn_d, btn_l, btn_r} = 4'b0;
    repeat (15) step();
    if (rejected) snap_pulse();
  endtask

  task automatic pix(int i, int e);
    pix_q.push_back(e);
    step();
    pixel_index = 13'(i);
    pix_tag = 1'b1;
    step();
    pix_tag = 1'b0;
    repeat (3) step();
  endtask

  task automatic check_item(int acc);
    item_t it;
    bit    ok;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output: x=%0d y=%0d goal=%0d busy_cycles=%0d, required no output",
               player_x, player_y, goal_reached, acc);
      return;
    end
    it = exp_q.pop_front();
    ok = (int'(player_x) == it.x) && (int'(player_y) == it.y) &&
         (int'(goal_reached) == it.goal) && (acc >= it.bmin) && (acc <= it.bmax) &&
         (it.chk_oled == 0 || int'(oled_data) == it.oled);
    if (!ok) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d goal=%0d busy_cycles=%0d oled=%h, required x=%0d y=%0d goal=%0d busy_cycles=%0d..%0d oled=%h",
               it.name, player_x, player_y, goal_reached, acc, oled_data,
               it.x, it.y, it.goal, it.bmin, it.bmax, 16'(it.oled));
    end
  endtask

  // Monitor: pops expectations when the DUT finishes a move (busy falls),
  // when a snapshot is requested, and two cycles after each tagged pixel.
  int   s0 = 0, s1 = 0, s2 = 0, acc = 0, pe;
  logic pb = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      s2 = s1; s1 = s0; s0 = int'(pix_tag);
      if (s2 != 0) begin
        checks++;
        if (pix_q.size() == 0) begin
          errors++;
          $display("FAIL overlay_queue: oled=%h with no expectation pending", oled_data);
        end else begin
          pe = pix_q.pop_front();
          if (int'(oled_data) != pe) begin
            errors++;
            $display("FAIL overlay: oled_data=%h required %h", oled_data, 16'(pe));
          end
        end
      end
      if (!rst_n) acc = 0;
      else if (busy) acc++;
      if (rst_n && pb && !busy) begin
        check_item(acc);
        acc = 0;
      end
      if (snap) begin
        check_item(acc);
        acc = 0;
      end
      pb = busy;
    end
  end

  initial begin
    fill_maze(16'h0000);
    repeat (3) @(posedge clk);
    #1;
    expect_state("reset_state", 86, 3, 0, 0, 0, 1, 0);
    snap = 1'b1;
    step(); snap = 1'b0;
    rst_n = 1'b1;
    step();

    // Hold a pixel inside the sprite, move, then reset asynchronously mid-frame.
    pixel_index = 13'(idx(88, 3));
    move("first_right", 0, 0, 0, 1, 87, 3, 0, 11, 11, 0);
    pix(idx(88, 3), 16'h07E0);
    step();
    expect_state("async_reset", 86, 3, 0, 0, 0, 1, 0);
    rst_n = 1'b0;
    snap = 1'b1;
    step(); snap = 1'b0;
    step(); rst_n = 1'b1;
    step();

    move("open_right", 0, 0, 0, 1, 87, 3, 0, 11, 11, 0);
    pix(idx(87, 3), 16'h07E0);
    pix(idx(86, 3), 16'h0000);
    pix(idx(89, 5), 16'h07E0);
    pix(idx(90, 3), 16'h0000);
    pix(idx(87, 6), 16'h0000);

    for (int y = 0; y < 64; y++) maze[idx(90, y)] = 16'hFFFF;
    move("wall_abort", 0, 0, 0, 1, 87, 3, 0, 1, 5, 0);
    pix(idx(90, 3), 16'hFFFF);
    fill_maze(16'h0000);

    // Second tick lands while busy and must be dropped.
    expect_state("tick_while_busy", 86, 3, 0, 11, 11);
    step(); btn_l = 1'b1; move_tick = 1'b1;
    step(); move_tick = 1'b0; btn_l = 1'b0;
    step(); step();
    btn_l = 1'b1; move_tick = 1'b1;
    step(); move_tick = 1'b0; btn_l = 1'b0;
    repeat (20) step();

    move("two_buttons", 1, 0, 1, 0, 86, 3, 0, 0, 0, 1);
    move("no_buttons", 0, 0, 0, 0, 86, 3, 0, 0, 0, 1);
    move("up_1", 1, 0, 0, 0, 86, 2, 0, 11, 11, 0);
    move("up_2", 1, 0, 0, 0, 86, 1, 0, 11, 11, 0);
    move("up_3", 1, 0, 0, 0, 86, 0, 0, 11, 11, 0);
    move("up_at_top", 1, 0, 0, 0, 86, 0, 0, 0, 0, 1);

    for (int k = 1; k <= 17; k++) move("walk_down", 0, 1, 0, 0, 86, k, 0, 11, 11, 0);
    for (int k = 85; k >= 10; k--) move("walk_left", 0, 0, 1, 0, k, 17, 0, 11, 11, 0);

    maze[idx(10, 20)] = 16'h001F;
    move("goal_hit", 0, 1, 0, 0, 10, 18, 1, 11, 11, 0);
    move("goal_frozen", 0, 1, 0, 0, 10, 18, 1, 0, 0, 1);
    fill_maze(16'h0000);

    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    expect_state("goal_cleared", 86, 3, 0, 0, 0);
    snap_pulse();

    expect_state("reset_in_probe", 86, 3, 0, 0, 0);
    step(); btn_r = 1'b1; move_tick = 1'b1;
    step(); move_tick = 1'b0; btn_r = 1'b0;
    step(); step();
    rst_n = 1'b0; snap = 1'b1;
    step(); snap = 1'b0; rst_n = 1'b1;
    repeat (15) step();
    expect_state("no_commit_after_reset", 86, 3, 0, 0, 0);
    snap_pulse();
    move("move_after_reset", 0, 0, 0, 1, 87, 3, 0, 11, 11, 0);

    repeat (5) step();
    checks++;
    if (exp_q.size() != 0 || pix_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: pending=%0d/%0d required 0/0",
               exp_q.size(), pix_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
